jtag_vio: RTL

- Virtual I/O responder on the second side of the GW_JTAG user-register path, complementing the capture-only analyzer.
- The host shifts a data register through the ER1/ER2 user chain. The block returns sampled `probe_in` bits on `tdo` and drives `probe_out` from the shifted-in bits on Update-DR.
- Runs entirely in the system clock domain and oversamples the JTAG primitive's decoded signals, so there is no TCK clock domain in the fabric.

---
 rtl/jtag_vio_pkg.sv | 16 +
 rtl/jtag_sync_edge.sv | 30 +++
 rtl/jtag_vio.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jtag_vio_pkg.sv
// Shared types and helpers for the jtag_vio virtual I/O responder.
package jtag_vio_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    UPD   = 2'd2
  } state_t;

  function automatic int dr_width(input int in_w, input int out_w);
    return (in_w > out_w) ? in_w : out_w;
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Synchroniser for one asynchronous JTAG strobe, plus a delay stage for edge detection.
module jtag_sync_edge
  import jtag_vio_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_lvl  = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/jtag_vio.sv
// Virtual I/O on a GW_JTAG user chain; oversamples the TAP strobes in the clk domain.
// Define JTAG_VIO_PULSE_EN to make probe_out[0] self-clear after PULSE_CYC clk.
module jtag_vio
  import jtag_vio_pkg::*;
#(
  parameter int               IN_W      = 8,
  parameter int               OUT_W     = 8,
  parameter logic [OUT_W-1:0] OUT_INIT  = '0,
  parameter int               PULSE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jtag_tck,
  input  logic             jtag_tdi,
  input  logic             jtag_tlr,
  input  logic             jtag_en,
  input  logic             jtag_sdr_cdr,
  input  logic             jtag_udr,
  output logic             jtag_tdo,
  input  logic [IN_W-1:0]  probe_in,
  output logic [OUT_W-1:0] probe_out,
  output logic             update_stb
);

  localparam int DR_W = dr_width(IN_W, OUT_W);
  localparam int I_TCK = 0, I_TDI = 1, I_TLR = 2, I_EN = 3, I_SDR = 4, I_UDR = 5;

  logic [5:0] w_in, w_lvl, w_rise, w_fall;
  assign w_in = {jtag_udr, jtag_sdr_cdr, jtag_en, jtag_tlr, jtag_tdi, jtag_tck};

  jtag_sync_edge u_sync [5:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_in),
    .o_lvl (w_lvl),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  logic w_tck_rise, w_tck_fall, w_udr_rise, w_tdi, w_tlr, w_en, w_sdr, w_unused;
  assign w_tck_rise = w_rise[I_TCK];
  assign w_tck_fall = w_fall[I_TCK];
  assign w_udr_rise = w_rise[I_UDR];
  assign w_tdi      = w_lvl[I_TDI];
  assign w_tlr      = w_lvl[I_TLR];
  assign w_en       = w_lvl[I_EN];
  assign w_sdr      = w_lvl[I_SDR];
  assign w_unused   = ^{w_rise[4:1], w_fall[5:1], w_lvl[I_TCK], w_lvl[I_UDR]};

  state_t            r_state, w_next;
  logic [DR_W-1:0]   r_sr;
  logic              r_paused, r_tdo, r_stb;
  logic [OUT_W-1:0]  r_out;
  logic              w_capture, w_shift, w_upd, w_leave;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // tlr beats everything, then udr_rise beats any tck activity.
  always_comb begin
    w_next = r_state;
    if (w_tlr)                    w_next = IDLE;
    else if (w_udr_rise && w_en)  w_next = UPD;
    else begin
      case (r_state)
        IDLE:    if (w_tck_rise && w_en && w_sdr) w_next = SHIFT;
        SHIFT:   if (!w_en || !w_sdr)             w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Re-entry from IDLE while paused is a resumed Shift-DR, not a new Capture-DR.
  always_comb begin
    w_capture = (r_state == IDLE) && (w_next == SHIFT) && !r_paused;
    w_shift   = ((r_state == SHIFT) && (w_next == SHIFT) && w_tck_rise) ||
                ((r_state == IDLE) && (w_next == SHIFT) && r_paused);
    w_upd     = (r_state == UPD) && !w_tlr;
    w_leave   = (r_state == SHIFT) && (w_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_paused <= 1'b0;
    end else begin
      if (w_tlr)          r_sr <= '0;
      else if (w_capture) r_sr <= DR_W'(probe_in);
      else if (w_shift)   r_sr <= {w_tdi, r_sr[DR_W-1:1]};

      if (w_tlr || w_udr_rise)   r_paused <= 1'b0;
      else if (w_leave && w_en)  r_paused <= 1'b1;
    end
  end

  // tdo moves on the falling TCK so it is settled before the host's rising sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_tdo <= 1'b0;
    else if (w_tck_fall && w_en)     r_tdo <= r_sr[0];
  end

`ifdef JTAG_VIO_PULSE_EN
  localparam int CNT_W = $clog2(PULSE_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= OUT_INIT;
      r_stb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_stb <= w_upd;
      if (w_upd) begin
        r_out <= r_sr[OUT_W-1:0];
        r_cnt <= r_sr[0] ? CNT_W'(PULSE_CYC) : '0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) r_out[0] <= 1'b0;
      end
    end
  end
`else
  localparam int unused_pulse_cyc = PULSE_CYC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= OUT_INIT;
      r_stb <= 1'b0;
    end else begin
      r_stb <= w_upd;
      if (w_upd) r_out <= r_sr[OUT_W-1:0];
    end
  end
`endif

  assign jtag_tdo   = r_tdo;
  assign probe_out  = r_out;
  assign update_stb = r_stb;

endmodule
